rob_nway_squash: RTL and testbench

//  N-wide reorder buffer between dispatch and retire in the R10K pipeline.

---
 rtl/rob_nway_squash_if.sv | 45 ++++
 rtl/rob_nway_squash.sv | 170 +++++++++++++++++
 tb/tb_rob_nway_squash.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_nway_squash_if.sv
// Dispatch / complete / squash / retire bundle between the R10K pipeline and its reorder buffer.
// The pipeline side drives through master; the ROB sits behind slave.
interface rob_nway_squash_if #(
    parameter int DEPTH  = 32,
    parameter int N      = 2,
    parameter int PREG_W = 6,
    parameter int AREG_W = 5
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [N-1:0]        disp_valid;
    logic [N*PREG_W-1:0] disp_t;
    logic [N*PREG_W-1:0] disp_told;
    logic [N*AREG_W-1:0] disp_areg;
    logic [N-1:0]        disp_has_dest;
    logic [N*IDX_W-1:0]  disp_idx;
    logic [CNT_W-1:0]    open_entries;

    logic [N-1:0]        cmp_valid;
    logic [N*IDX_W-1:0]  cmp_idx;

    logic                squash_valid;
    logic [IDX_W-1:0]    squash_idx;

    logic [N-1:0]        ret_valid;
    logic [N*PREG_W-1:0] ret_t;
    logic [N*PREG_W-1:0] ret_told;
    logic [N*AREG_W-1:0] ret_areg;
    logic [N-1:0]        ret_has_dest;

    modport master (
        output disp_valid, disp_t, disp_told, disp_areg, disp_has_dest,
        output cmp_valid, cmp_idx, squash_valid, squash_idx,
        input  disp_idx, open_entries,
        input  ret_valid, ret_t, ret_told, ret_areg, ret_has_dest
    );

    modport slave (
        input  disp_valid, disp_t, disp_told, disp_areg, disp_has_dest,
        input  cmp_valid, cmp_idx, squash_valid, squash_idx,
        output disp_idx, open_entries,
        output ret_valid, ret_t, ret_told, ret_areg, ret_has_dest
    );
endinterface

// File: rtl/rob_nway_squash.sv
// N-wide circular reorder buffer: in-order dispatch, out-of-order completion by index,
// in-order retire of up to N complete entries, and single-cycle squash of everything younger than a branch.
module rob_nway_squash #(
    parameter int DEPTH  = 32,
    parameter int N      = 2,
    parameter int PREG_W = 6,
    parameter int AREG_W = 5
) (
    input logic clock,
    input logic reset,
    rob_nway_squash_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    idx_t head_q, head_d;
    idx_t tail_q, tail_d;
    cnt_t count_q, count_d;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  complete_q, complete_d;
    logic [DEPTH-1:0]  has_dest_q, has_dest_d;
    logic [PREG_W-1:0] t_q    [DEPTH];
    logic [PREG_W-1:0] t_d    [DEPTH];
    logic [PREG_W-1:0] told_q [DEPTH];
    logic [PREG_W-1:0] told_d [DEPTH];
    logic [AREG_W-1:0] areg_q [DEPTH];
    logic [AREG_W-1:0] areg_d [DEPTH];

    logic [N-1:0]        ret_valid;
    logic [N*PREG_W-1:0] ret_t;
    logic [N*PREG_W-1:0] ret_told;
    logic [N*AREG_W-1:0] ret_areg;
    logic [N-1:0]        ret_has_dest;
    logic [N*IDX_W-1:0]  disp_idx;
    logic [N-1:0]        disp_ok;
    cnt_t                ret_cnt;
    cnt_t                disp_cnt;
    cnt_t                open_entries;
    logic                ret_run;
    idx_t                ret_ptr;
    idx_t                cmp_ptr;
    idx_t                wr_ptr;
    idx_t                age_off;
    idx_t                squash_off;

    // Retire walks from head and stops at the first entry that is not both live and complete.
    always_comb begin
        ret_valid    = '0;
        ret_cnt      = '0;
        ret_t        = '0;
        ret_told     = '0;
        ret_areg     = '0;
        ret_has_dest = '0;
        ret_run      = 1'b1;
        ret_ptr      = '0;
        for (int k = 0; k < N; k++) begin
            ret_ptr      = head_q + idx_t'(k);
            ret_run      = ret_run && (cnt_t'(k) < count_q) && valid_q[ret_ptr] && complete_q[ret_ptr];
            ret_valid[k] = ret_run;
            ret_cnt      = ret_cnt + cnt_t'(ret_run);
            ret_t[k*PREG_W +: PREG_W]    = t_q[ret_ptr];
            ret_told[k*PREG_W +: PREG_W] = told_q[ret_ptr];
            ret_areg[k*AREG_W +: AREG_W] = areg_q[ret_ptr];
            ret_has_dest[k]              = has_dest_q[ret_ptr];
        end
    end

    always_comb begin
        open_entries = cnt_t'(DEPTH) - count_q;
        disp_ok      = '0;
        disp_cnt     = '0;
        disp_idx     = '0;
        for (int i = 0; i < N; i++) begin
            disp_ok[i] = bus.disp_valid[i] && (cnt_t'(i) < open_entries) && !bus.squash_valid;
            disp_cnt   = disp_cnt + cnt_t'(disp_ok[i]);
            disp_idx[i*IDX_W +: IDX_W] = tail_q + idx_t'(i);
        end
    end

    // Squash is applied last so it also overrides completions landing on the discarded entries.
    always_comb begin
        head_d     = head_q + idx_t'(ret_cnt);
        tail_d     = tail_q + idx_t'(disp_cnt);
        count_d    = count_q + disp_cnt - ret_cnt;
        valid_d    = valid_q;
        complete_d = complete_q;
        has_dest_d = has_dest_q;
        t_d        = t_q;
        told_d     = told_q;
        areg_d     = areg_q;
        cmp_ptr    = '0;
        wr_ptr     = '0;
        age_off    = '0;
        squash_off = bus.squash_idx - head_q;

        for (int j = 0; j < N; j++) begin
            cmp_ptr = bus.cmp_idx[j*IDX_W +: IDX_W];
            if (bus.cmp_valid[j] && valid_q[cmp_ptr]) begin
                complete_d[cmp_ptr] = 1'b1;
            end
        end

        for (int k = 0; k < N; k++) begin
            if (ret_valid[k]) begin
                valid_d[head_q + idx_t'(k)]    = 1'b0;
                complete_d[head_q + idx_t'(k)] = 1'b0;
            end
        end

        for (int i = 0; i < N; i++) begin
            wr_ptr = tail_q + idx_t'(i);
            if (disp_ok[i]) begin
                valid_d[wr_ptr]    = 1'b1;
                complete_d[wr_ptr] = 1'b0;
                has_dest_d[wr_ptr] = bus.disp_has_dest[i];
                t_d[wr_ptr]        = bus.disp_t[i*PREG_W +: PREG_W];
                told_d[wr_ptr]     = bus.disp_told[i*PREG_W +: PREG_W];
                areg_d[wr_ptr]     = bus.disp_areg[i*AREG_W +: AREG_W];
            end
        end

        if (bus.squash_valid) begin
            for (int e = 0; e < DEPTH; e++) begin
                age_off = idx_t'(e) - head_q;
                if ((age_off > squash_off) && (cnt_t'(age_off) < count_q)) begin
                    valid_d[e]    = 1'b0;
                    complete_d[e] = 1'b0;
                end
            end
            tail_d  = bus.squash_idx + idx_t'(1);
            count_d = cnt_t'(squash_off) + cnt_t'(1) - ret_cnt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            complete_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            complete_q <= complete_d;
        end
    end

    // Payload is only meaningful behind a valid bit, so it carries no reset.
    always_ff @(posedge clock) begin
        has_dest_q <= has_dest_d;
        t_q        <= t_d;
        told_q     <= told_d;
        areg_q     <= areg_d;
    end

    assign bus.disp_idx     = disp_idx;
    assign bus.open_entries = open_entries;
    assign bus.ret_valid    = ret_valid;
    assign bus.ret_t        = ret_t;
    assign bus.ret_told     = ret_told;
    assign bus.ret_areg     = ret_areg;
    assign bus.ret_has_dest = ret_has_dest;
endmodule

// File: tb/tb_rob_nway_squash.sv
// Bench for rob_nway_squash: directed corner cases followed by random traffic, all checked
// against a program-order queue model of the buffer.
module tb_rob_nway_squash;
    localparam int DEPTH  = 32;
    localparam int N      = 2;
    localparam int PREG_W = 6;
    localparam int AREG_W = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    rob_nway_squash_if #(.DEPTH(DEPTH), .N(N), .PREG_W(PREG_W), .AREG_W(AREG_W)) bus ();

    rob_nway_squash #(.DEPTH(DEPTH), .N(N), .PREG_W(PREG_W), .AREG_W(AREG_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          idx;
        logic [5:0]  t;
        logic [5:0]  told;
        logic [4:0]  areg;
        logic        hd;
        logic        cmp;
    } ent_t;

    ent_t rob[$];
    int   m_head;
    int   checks;
    int   errors;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int modelRetCount();
        int n = 0;
        for (int k = 0; k < N; k++) begin
            if (k < rob.size() && rob[k].cmp) n++;
            else break;
        end
        return n;
    endfunction

    // One cycle: drive inputs, check outputs against the model, clock, then advance the model.
    task automatic applyStimulus(input logic [1:0] dv, input logic [1:0] cv, input int c0, input int c1,
                                 input logic sv, input int si);
        int         sz, nret, open, tail, pos;
        int         cidx[2];
        logic [1:0] erv;
        ent_t       e;
        bus.disp_valid    = dv;
        bus.disp_t        = 12'($urandom);
        bus.disp_told     = 12'($urandom);
        bus.disp_areg     = 10'($urandom);
        bus.disp_has_dest = 2'($urandom);
        bus.cmp_valid     = cv;
        bus.cmp_idx       = {5'(c1), 5'(c0)};
        bus.squash_valid  = sv;
        bus.squash_idx    = 5'(si);
        #1;
        sz   = rob.size();
        nret = modelRetCount();
        open = DEPTH - sz;
        tail = (m_head + sz) % DEPTH;
        checkOutput("open_entries", 32'(bus.open_entries), open);
        for (int i = 0; i < N; i++)
            checkOutput("disp_idx", 32'(bus.disp_idx[i*5 +: 5]), (tail + i) % DEPTH);
        erv = '0;
        for (int k = 0; k < N; k++) erv[k] = (k < nret);
        checkOutput("ret_valid", 32'(bus.ret_valid), 32'(erv));
        for (int k = 0; k < nret; k++) begin
            checkOutput("ret_t",    32'(bus.ret_t[k*6 +: 6]),    32'(rob[k].t));
            checkOutput("ret_told", 32'(bus.ret_told[k*6 +: 6]), 32'(rob[k].told));
            checkOutput("ret_areg", 32'(bus.ret_areg[k*5 +: 5]), 32'(rob[k].areg));
            checkOutput("ret_hd",   32'(bus.ret_has_dest[k]),    32'(rob[k].hd));
        end
        @(posedge clock);
        #1;
        cidx[0] = c0;
        cidx[1] = c1;
        for (int j = 0; j < N; j++)
            if (cv[j])
                foreach (rob[q]) if (rob[q].idx == cidx[j]) rob[q].cmp = 1'b1;
        if (sv) begin
            pos = (si - m_head + DEPTH) % DEPTH;
            while (rob.size() > pos + 1) void'(rob.pop_back());
        end
        repeat (nret) void'(rob.pop_front());
        m_head = (m_head + nret) % DEPTH;
        if (!sv) begin
            for (int i = 0; i < N; i++) begin
                if (dv[i] && i < open) begin
                    e.idx  = (tail + i) % DEPTH;
                    e.t    = bus.disp_t[i*6 +: 6];
                    e.told = bus.disp_told[i*6 +: 6];
                    e.areg = bus.disp_areg[i*5 +: 5];
                    e.hd   = bus.disp_has_dest[i];
                    e.cmp  = 1'b0;
                    rob.push_back(e);
                end
            end
        end
    endtask

    task automatic resetDut();
        reset             = 1'b1;
        bus.disp_valid    = '0;
        bus.cmp_valid     = '0;
        bus.squash_valid  = 1'b0;
        @(posedge clock);
        #1;
        reset  = 1'b0;
        rob.delete();
        m_head = 0;
    endtask

    task automatic autoComplete(output logic [1:0] cv, output int c0, output int c1);
        int n = 0;
        cv = '0;
        c0 = 0;
        c1 = 0;
        foreach (rob[q]) begin
            if (!rob[q].cmp && n < 2) begin
                if (n == 0) c0 = rob[q].idx;
                else        c1 = rob[q].idx;
                cv[n] = 1'b1;
                n++;
            end
        end
    endtask

    initial begin
        logic [1:0] cv, dv;
        int         c0, c1, nret, pos, sz;
        logic       sv;
        checks = 0;
        errors = 0;
        m_head = 0;
        bus.disp_valid    = '0;
        bus.disp_t        = '0;
        bus.disp_told     = '0;
        bus.disp_areg     = '0;
        bus.disp_has_dest = '0;
        bus.cmp_valid     = '0;
        bus.cmp_idx       = '0;
        bus.squash_valid  = 1'b0;
        bus.squash_idx    = '0;

        $display("[TB] fill to full, then dispatch into a full buffer");
        resetDut();
        repeat (16) applyStimulus(2'b11, 2'b00, 0, 0, 1'b0, 0);
        checkOutput("t1_full_open", 32'(bus.open_entries), 0);
        applyStimulus(2'b11, 2'b00, 0, 0, 1'b0, 0);
        checkOutput("t1_tail_stays", 32'(bus.disp_idx[4:0]), 0);

        $display("[TB] out-of-order completion, two-wide retire");
        resetDut();
        repeat (2) applyStimulus(2'b11, 2'b00, 0, 0, 1'b0, 0);
        applyStimulus(2'b00, 2'b11, 1, 0, 1'b0, 0);
        checkOutput("t2_ret_both", 32'(bus.ret_valid), 32'h3);
        applyStimulus(2'b00, 2'b01, 2, 0, 1'b0, 0);
        checkOutput("t2_ret_one", 32'(bus.ret_valid), 32'h1);

        $display("[TB] index wrap around the end of the buffer");
        resetDut();
        repeat (15) begin
            autoComplete(cv, c0, c1);
            applyStimulus(2'b11, cv, c0, c1, 1'b0, 0);
        end
        for (int n = 0; n < 20 && rob.size() > 0; n++) begin
            autoComplete(cv, c0, c1);
            applyStimulus(2'b00, cv, c0, c1, 1'b0, 0);
        end
        checkOutput("t3_head30", 32'(bus.disp_idx[4:0]), 30);
        repeat (2) applyStimulus(2'b11, 2'b00, 0, 0, 1'b0, 0);
        repeat (4) begin
            autoComplete(cv, c0, c1);
            applyStimulus(2'b00, cv, c0, c1, 1'b0, 0);
        end
        checkOutput("t3_open", 32'(bus.open_entries), 32);
        checkOutput("t3_tail", 32'(bus.disp_idx[4:0]), 2);

        $display("[TB] squash with same-cycle dispatch");
        resetDut();
        repeat (4) applyStimulus(2'b11, 2'b00, 0, 0, 1'b0, 0);
        applyStimulus(2'b11, 2'b00, 0, 0, 1'b1, 3);
        checkOutput("t4_open", 32'(bus.open_entries), 28);
        checkOutput("t4_tail", 32'(bus.disp_idx[4:0]), 4);
        applyStimulus(2'b00, 2'b11, 4, 5, 1'b0, 0);
        applyStimulus(2'b00, 2'b11, 6, 7, 1'b0, 0);
        applyStimulus(2'b00, 2'b11, 0, 1, 1'b0, 0);
        applyStimulus(2'b00, 2'b11, 2, 3, 1'b0, 0);
        repeat (3) applyStimulus(2'b00, 2'b00, 0, 0, 1'b0, 0);
        checkOutput("t4_drained", 32'(bus.open_entries), 32);

        $display("[TB] squash on the branch retiring this cycle");
        resetDut();
        applyStimulus(2'b01, 2'b00, 0, 0, 1'b0, 0);
        applyStimulus(2'b00, 2'b01, 0, 0, 1'b0, 0);
        applyStimulus(2'b00, 2'b00, 0, 0, 1'b1, 0);
        checkOutput("t5_open", 32'(bus.open_entries), 32);
        checkOutput("t5_tail", 32'(bus.disp_idx[4:0]), 1);

        $display("[TB] reset with live entries");
        repeat (5) applyStimulus(2'b11, 2'b00, 0, 0, 1'b0, 0);
        resetDut();
        checkOutput("t6_ret", 32'(bus.ret_valid), 0);
        checkOutput("t6_open", 32'(bus.open_entries), 32);
        checkOutput("t6_idx", 32'(bus.disp_idx), 32'h20);

        $display("[TB] random traffic");
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if ($urandom_range(0, 299) == 0) resetDut();
            sz = rob.size();
            case ($urandom_range(0, 3))
                0:       dv = 2'b00;
                1:       dv = 2'b01;
                default: dv = 2'b11;
            endcase
            cv = '0;
            c0 = int'($urandom_range(0, DEPTH - 1));
            c1 = int'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 3) != 0) begin
                cv[0] = 1'b1;
                if (sz > 0 && $urandom_range(0, 9) != 0) c0 = rob[$urandom_range(0, sz - 1)].idx;
            end
            if ($urandom_range(0, 3) != 0) begin
                cv[1] = 1'b1;
                if (sz > 0 && $urandom_range(0, 9) != 0) c1 = rob[$urandom_range(0, sz - 1)].idx;
            end
            sv   = 1'b0;
            pos  = 0;
            nret = modelRetCount();
            if (sz > 0 && $urandom_range(0, 15) == 0) begin
                sv  = 1'b1;
                pos = (nret == 0) ? int'($urandom_range(0, sz - 1))
                                  : (nret - 1) + int'($urandom_range(0, sz - nret));
            end
            applyStimulus(dv, cv, c0, c1, sv, (m_head + pos) % DEPTH);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
